// File: rtl/prog_loader.sv
// prog_loader: loads a framed byte stream into program memory, holding the CPU in reset
// until the payload checksum verifies.
module prog_loader #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 65535
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int HW = ADDR_W - DATA_W;
    localparam int IW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    localparam logic [IW-1:0] TO_LAST = IW'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, DONE, ERR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [IW-1:0]     idle_q, idle_d;
    logic [HW-1:0]     len_hi_q, len_hi_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] sum_next;
    logic [ADDR_W-1:0] len;
    logic              accept;
    logic              timeout_hit;

    assign busy        = state_q inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM};
    assign in_ready    = busy;
    assign done        = state_q == DONE;
    assign err         = state_q == ERR;
    assign cpu_hold    = busy | err;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign accept      = busy && in_valid;
    assign sum_next    = sum_q + in_data;
    assign len         = {len_hi_q, in_data};
    assign timeout_hit = TIMEOUT != 0 && idle_q == TO_LAST;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        sum_d       = sum_q;
        idle_d      = idle_q;
        len_hi_d    = len_hi_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (!busy) begin
            if (start) begin
                state_d = S_LEN_HI;
                addr_d  = '0;
                sum_d   = '0;
                idle_d  = '0;
            end
        end else if (accept) begin
            idle_d = '0;
            case (state_q)
                S_LEN_HI: begin
                    len_hi_d = in_data[HW-1:0];
                    state_d  = in_data[DATA_W-1:HW] == '0 ? S_LEN_LO : ERR;
                end
                S_LEN_LO: begin
                    // a zero length means a full memory image: 2^ADDR_W bytes
                    rem_d   = {len == '0, len};
                    state_d = S_DATA;
                end
                S_DATA: begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = in_data;
                    addr_d      = addr_q + 1'b1;
                    sum_d       = sum_next;
                    rem_d       = rem_q - 1'b1;
                    state_d     = rem_q == (ADDR_W+1)'(1) ? S_CSUM : S_DATA;
                end
                S_CSUM:  state_d = sum_next == '0 ? DONE : ERR;
                default: ;
            endcase
        end else begin
            idle_d  = idle_q + 1'b1;
            state_d = timeout_hit ? ERR : state_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            sum_q       <= '0;
            idle_q      <= '0;
            len_hi_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            sum_q       <= sum_d;
            idle_q      <= idle_d;
            len_hi_q    <= len_hi_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed frames against a write-scoreboard and frame-level outcome model.
module tb_prog_loader;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, mem_we, cpu_hold, busy, done, err;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;

    prog_loader #(.ADDR_W(12), .DATA_W(8), .TIMEOUT(16)) dut (
        .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    typedef struct packed {logic [11:0] a; logic [7:0] d;} wr_t;
    wr_t         exp_q[$];
    logic [7:0]  mem [4096];
    logic [11:0] last_addr = 12'h000;
    int          wr_cnt = 0;
    int          checks = 0;
    int          passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    initial forever begin
        @(negedge clock);
        if (!reset) begin
            chk("ready_eq_busy", 32'(in_ready), 32'(busy));
            chk("hold_rule", 32'(cpu_hold), 32'(busy | err));
            if (mem_we) begin
                mem[mem_addr] = mem_wdata;
                last_addr = mem_addr;
                wr_cnt++;
                chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    wr_t w;
                    w = exp_q.pop_front();
                    chk("wr_addr", 32'(mem_addr), 32'(w.a));
                    chk("wr_data", 32'(mem_wdata), 32'(w.d));
                end
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("ready_wait", 32'(in_ready), 32'd1);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic expect_write(input int i, input logic [7:0] d);
        wr_t w;
        w.a = 12'(i);
        w.d = d;
        exp_q.push_back(w);
    endtask

    task automatic load(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] data[$],
                        input logic [7:0] cs);
        logic [7:0] s = 8'h00;
        logic       ok;
        pulse_start();
        send(hi);
        send(lo);
        foreach (data[i]) begin
            s += data[i];
            expect_write(i, data[i]);
            send(data[i]);
        end
        send(cs);
        ok = 8'(s + cs) == 8'h00;
        chk("load_done", 32'(done), 32'(ok));
        chk("load_err", 32'(err), 32'(!ok));
        chk("load_hold", 32'(cpu_hold), 32'(!ok));
        chk("load_busy", 32'(busy), 32'd0);
        chk("writes_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at 2ms, expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] q[$];
        logic [7:0] s;
        repeat (2) @(negedge clock);
        check_zero("reset");
        reset = 1'b0;
        @(negedge clock);

        q = {8'hA5, 8'h5A, 8'h01};
        load(8'h00, 8'h03, q, 8'h00);
        chk("basic_m0", 32'(mem[0]), 32'hA5);
        chk("basic_m1", 32'(mem[1]), 32'h5A);
        chk("basic_m2", 32'(mem[2]), 32'h01);
        chk("basic_wrs", 32'(wr_cnt), 32'd3);
        chk("basic_done", 32'(done), 32'd1);

        load(8'h00, 8'h03, q, 8'h01);
        chk("badcs_err", 32'(err), 32'd1);
        chk("badcs_wrs", 32'(wr_cnt), 32'd6);
        repeat (3) @(negedge clock);
        chk("badcs_hold", 32'(cpu_hold), 32'd1);

        pulse_start();
        send(8'h10);
        chk("hdr_err", 32'(err), 32'd1);
        chk("hdr_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clock);
        chk("hdr_wrs", 32'(wr_cnt), 32'd6);

        q.delete();
        s = 8'h00;
        for (int i = 0; i < 4096; i++) begin
            q.push_back(8'(i));
            s += 8'(i);
        end
        load(8'h00, 8'h00, q, 8'(-s));
        chk("full_last", 32'(last_addr), 32'hFFF);
        chk("full_done", 32'(done), 32'd1);
        chk("full_wrs", 32'(wr_cnt), 32'd4102);
        q = {8'h7E};
        load(8'h00, 8'h01, q, 8'h82);
        chk("after_full_m0", 32'(mem[0]), 32'h7E);
        chk("after_full_last", 32'(last_addr), 32'h000);

        pulse_start();
        send(8'h00);
        send(8'h05);
        expect_write(0, 8'h11);
        send(8'h11);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clock);
            if (i == 15) chk("to_not_yet", 32'(err), 32'd0);
        end
        chk("to_err", 32'(err), 32'd1);
        chk("to_busy", 32'(busy), 32'd0);
        chk("to_writes_left", 32'(exp_q.size()), 32'd0);

        pulse_start();
        send(8'h00);
        send(8'h02);
        expect_write(0, 8'h10);
        send(8'h10);
        expect_write(1, 8'h20);
        start = 1'b1;
        send(8'h20);
        start = 1'b0;
        send(8'hD0);
        chk("startbusy_done", 32'(done), 32'd1);
        chk("startbusy_m1", 32'(mem[1]), 32'h20);
        chk("startbusy_last", 32'(last_addr), 32'h001);
        chk("startbusy_left", 32'(exp_q.size()), 32'd0);

        pulse_start();
        send(8'h00);
        send(8'h04);
        expect_write(0, 8'h01);
        send(8'h01);
        expect_write(1, 8'h02);
        send(8'h02);
        #2 reset = 1'b1;
        #1 check_zero("midreset");
        chk("midreset_left", 32'(exp_q.size()), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        @(negedge clock);
        q = {8'h55};
        load(8'h00, 8'h01, q, 8'hAB);
        chk("clean_m0", 32'(mem[0]), 32'h55);
        chk("clean_done", 32'(done), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
